// File: rtl/fb_id_ex_if.sv
// fb_id_ex_if: ID-side inputs, EX-side register outputs and hazard/counter signals of the ID/EX stage
interface fb_id_ex_if #(parameter int XLEN = 32, parameter int CNT_W = 16);
    logic             id_valid;
    logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic [3:0]       id_funct;
    logic [1:0]       id_alu_op;
    logic             id_alu_src, id_alu_res_src, id_mem_read, id_mem_write, id_branch, id_mem_to_reg, id_reg_write;
    logic             flush, hold;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [3:0]       ex_funct;
    logic [1:0]       ex_alu_op;
    logic             ex_alu_src, ex_alu_res_src, ex_mem_read, ex_mem_write, ex_branch, ex_mem_to_reg, ex_reg_write;
    logic             stall_if_id;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, id_funct, id_alu_op,
               id_alu_src, id_alu_res_src, id_mem_read, id_mem_write, id_branch, id_mem_to_reg, id_reg_write,
               flush, hold,
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct, ex_alu_op,
               ex_alu_src, ex_alu_res_src, ex_mem_read, ex_mem_write, ex_branch, ex_mem_to_reg, ex_reg_write,
               stall_if_id, bubble_cnt, flush_cnt
    );
    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd, id_funct, id_alu_op,
               id_alu_src, id_alu_res_src, id_mem_read, id_mem_write, id_branch, id_mem_to_reg, id_reg_write,
               flush, hold,
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct, ex_alu_op,
               ex_alu_src, ex_alu_res_src, ex_mem_read, ex_mem_write, ex_branch, ex_mem_to_reg, ex_reg_write,
               stall_if_id, bubble_cnt, flush_cnt
    );
endinterface

// File: rtl/fb_id_ex_stage.sv
// fb_id_ex_stage: ID/EX pipeline register with load-use bubble insertion, flush/hold priority and saturating event counters
module fb_id_ex_stage #(parameter int XLEN = 32, parameter int CNT_W = 16) (
    input logic clk,
    input logic rst,
    fb_id_ex_if.slave bus
);
    logic lu, keep, load_id, ld_valid;

    always_comb begin
        lu = bus.ex_valid & bus.ex_mem_read & (bus.ex_rd != 5'd0) & bus.id_valid &
             ((bus.ex_rd == bus.id_rs1) | (bus.ex_rd == bus.id_rs2));
        bus.stall_if_id = lu & ~bus.flush & ~bus.hold;
        keep = bus.hold & ~bus.flush;
        load_id = ~bus.flush & ~bus.hold & ~lu;
        ld_valid = load_id & bus.id_valid;
    end

    // A bubble clears data as well as control so the EX register is deterministic
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ex_valid <= 1'b0;
            bus.ex_pc <= XLEN'(0);
            bus.ex_rs1_data <= XLEN'(0);
            bus.ex_rs2_data <= XLEN'(0);
            bus.ex_imm <= XLEN'(0);
            bus.ex_rs1 <= 5'd0;
            bus.ex_rs2 <= 5'd0;
            bus.ex_rd <= 5'd0;
            bus.ex_funct <= 4'd0;
            bus.ex_alu_op <= 2'b00;
            bus.ex_alu_src <= 1'b0;
            bus.ex_alu_res_src <= 1'b0;
            bus.ex_mem_read <= 1'b0;
            bus.ex_mem_write <= 1'b0;
            bus.ex_branch <= 1'b0;
            bus.ex_mem_to_reg <= 1'b0;
            bus.ex_reg_write <= 1'b0;
            bus.bubble_cnt <= CNT_W'(0);
            bus.flush_cnt <= CNT_W'(0);
        end else begin
            if (!keep) begin
                bus.ex_valid <= ld_valid;
                bus.ex_pc <= load_id ? bus.id_pc : XLEN'(0);
                bus.ex_rs1_data <= load_id ? bus.id_rs1_data : XLEN'(0);
                bus.ex_rs2_data <= load_id ? bus.id_rs2_data : XLEN'(0);
                bus.ex_imm <= load_id ? bus.id_imm : XLEN'(0);
                bus.ex_rs1 <= load_id ? bus.id_rs1 : 5'd0;
                bus.ex_rs2 <= load_id ? bus.id_rs2 : 5'd0;
                bus.ex_rd <= load_id ? bus.id_rd : 5'd0;
                bus.ex_funct <= load_id ? bus.id_funct : 4'd0;
                bus.ex_alu_op <= ld_valid ? bus.id_alu_op : 2'b00;
                bus.ex_alu_src <= ld_valid & bus.id_alu_src;
                bus.ex_alu_res_src <= ld_valid & bus.id_alu_res_src;
                bus.ex_mem_read <= ld_valid & bus.id_mem_read;
                bus.ex_mem_write <= ld_valid & bus.id_mem_write;
                bus.ex_branch <= ld_valid & bus.id_branch;
                bus.ex_mem_to_reg <= ld_valid & bus.id_mem_to_reg;
                bus.ex_reg_write <= ld_valid & bus.id_reg_write;
            end
            if (bus.flush & ~&bus.flush_cnt)
                bus.flush_cnt <= bus.flush_cnt + CNT_W'(1);
            if (bus.stall_if_id & ~&bus.bubble_cnt)
                bus.bubble_cnt <= bus.bubble_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_fb_id_ex_stage.sv
// tb_fb_id_ex_stage: directed vector table plus hand sequences for async reset and counter saturation
module tb_fb_id_ex_stage;
    logic clk, rst;
    int n_chk = 0, n_fail = 0;

    fb_id_ex_if #(.XLEN(32), .CNT_W(16)) bus();
    fb_id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic v; logic [31:0] pc, d1; logic [4:0] rs1, rs2, rd; logic mr, rw; logic [1:0] alu; logic fl, hd;
        logic s, ev; logic [31:0] epc, ed1; logic [4:0] erd; logic emr, erw; logic [1:0] ealu; logic [15:0] bc, fc;
    } vec_t;
    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t t);
        bus.id_valid = t.v;
        bus.id_pc = t.pc;
        bus.id_rs1_data = t.d1;
        bus.id_rs2_data = t.pc ^ 32'h15;
        bus.id_imm = t.pc << 4;
        bus.id_rs1 = t.rs1;
        bus.id_rs2 = t.rs2;
        bus.id_rd = t.rd;
        bus.id_funct = t.pc[5:2];
        bus.id_alu_op = t.alu;
        bus.id_mem_read = t.mr;
        bus.id_reg_write = t.rw;
        bus.flush = t.fl;
        bus.hold = t.hd;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".ex_valid"}, 32'(bus.ex_valid), 0);
        chk({tag, ".ex_pc"}, bus.ex_pc, 0);
        chk({tag, ".ex_rs1_data"}, bus.ex_rs1_data, 0);
        chk({tag, ".ex_rd"}, 32'(bus.ex_rd), 0);
        chk({tag, ".ex_mem_read"}, 32'(bus.ex_mem_read), 0);
        chk({tag, ".ex_reg_write"}, 32'(bus.ex_reg_write), 0);
        chk({tag, ".bubble_cnt"}, 32'(bus.bubble_cnt), 0);
        chk({tag, ".flush_cnt"}, 32'(bus.flush_cnt), 0);
        chk({tag, ".stall_if_id"}, 32'(bus.stall_if_id), 0);
    endtask

    initial begin
        //             v  pc     d1     rs1 rs2 rd mr rw alu fl hd | s ev epc    ed1    erd emr erw ealu bc fc
        tbl[0]  = '{1, 'h10, 'hA,  1, 2, 3, 0, 1, 2, 0, 0,  0, 1, 'h10, 'hA,  3, 0, 1, 2, 0, 0};
        tbl[1]  = '{1, 'h14, 'h100,1, 0, 5, 1, 1, 0, 0, 0,  0, 1, 'h14, 'h100,5, 1, 1, 0, 0, 0};
        tbl[2]  = '{1, 'h18, 'h7,  6, 5, 9, 0, 1, 2, 0, 0,  1, 0, 0,    0,    0, 0, 0, 0, 1, 0};
        tbl[3]  = '{1, 'h18, 'h7,  6, 5, 9, 0, 1, 2, 0, 0,  0, 1, 'h18, 'h7,  9, 0, 1, 2, 1, 0};
        tbl[4]  = '{1, 'h1C, 'h3,  0, 0, 0, 1, 1, 0, 0, 0,  0, 1, 'h1C, 'h3,  0, 1, 1, 0, 1, 0};
        tbl[5]  = '{1, 'h20, 'h4,  0, 0, 1, 0, 1, 2, 0, 0,  0, 1, 'h20, 'h4,  1, 0, 1, 2, 1, 0};
        tbl[6]  = '{1, 'h24, 'h11, 2, 0, 5, 1, 1, 0, 0, 0,  0, 1, 'h24, 'h11, 5, 1, 1, 0, 1, 0};
        tbl[7]  = '{1, 'h28, 'h12, 6, 7, 8, 0, 1, 2, 0, 0,  0, 1, 'h28, 'h12, 8, 0, 1, 2, 1, 0};
        tbl[8]  = '{1, 'h2C, 'h13, 0, 0, 5, 1, 1, 0, 0, 0,  0, 1, 'h2C, 'h13, 5, 1, 1, 0, 1, 0};
        tbl[9]  = '{1, 'h30, 'h14, 5, 0, 6, 0, 1, 2, 1, 0,  0, 0, 0,    0,    0, 0, 0, 0, 1, 1};
        tbl[10] = '{1, 'h34, 'h15, 0, 0, 5, 1, 1, 0, 0, 0,  0, 1, 'h34, 'h15, 5, 1, 1, 0, 1, 1};
        tbl[11] = '{1, 'h38, 'h16, 5, 0, 7, 0, 1, 2, 0, 1,  0, 1, 'h34, 'h15, 5, 1, 1, 0, 1, 1};
        tbl[12] = '{1, 'h38, 'h16, 5, 0, 7, 0, 1, 2, 0, 1,  0, 1, 'h34, 'h15, 5, 1, 1, 0, 1, 1};
        tbl[13] = '{1, 'h38, 'h16, 5, 0, 7, 0, 1, 2, 0, 1,  0, 1, 'h34, 'h15, 5, 1, 1, 0, 1, 1};
        tbl[14] = '{1, 'h38, 'h16, 5, 0, 7, 0, 1, 2, 0, 0,  1, 0, 0,    0,    0, 0, 0, 0, 2, 1};
        tbl[15] = '{1, 'h38, 'h16, 5, 0, 7, 0, 1, 2, 0, 0,  0, 1, 'h38, 'h16, 7, 0, 1, 2, 2, 1};
        tbl[16] = '{0, 'h3C, 'h17, 0, 0, 8, 1, 1, 3, 0, 0,  0, 0, 'h3C, 'h17, 8, 0, 0, 0, 2, 1};
        tbl[17] = '{1, 'h40, 'h18, 0, 0, 9, 0, 1, 2, 1, 1,  0, 0, 0,    0,    0, 0, 0, 0, 2, 2};
        tbl[18] = '{1, 'h44, 'h19, 0, 0, 5, 1, 1, 0, 0, 0,  0, 1, 'h44, 'h19, 5, 1, 1, 0, 2, 2};
        tbl[19] = '{0, 'h48, 'h1A, 5, 0, 1, 0, 1, 2, 0, 0,  0, 0, 'h48, 'h1A, 1, 0, 0, 0, 2, 2};

        bus.id_alu_src = 1'b1;
        bus.id_alu_res_src = 1'b1;
        bus.id_mem_write = 1'b1;
        bus.id_branch = 1'b1;
        bus.id_mem_to_reg = 1'b1;
        drive(tbl[0]);
        rst = 1'b0;
        #2 rst = 1'b1;
        #1 chk_zero("reset");
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            @(negedge clk);
            drive(tbl[i]);
            #1 chk({tag, ".stall_if_id"}, 32'(bus.stall_if_id), 32'(tbl[i].s));
            @(posedge clk);
            #1;
            chk({tag, ".ex_valid"}, 32'(bus.ex_valid), 32'(tbl[i].ev));
            chk({tag, ".ex_pc"}, bus.ex_pc, tbl[i].epc);
            chk({tag, ".ex_rs1_data"}, bus.ex_rs1_data, tbl[i].ed1);
            chk({tag, ".ex_rs2_data"}, bus.ex_rs2_data, tbl[i].epc == 0 ? 32'h0 : tbl[i].epc ^ 32'h15);
            chk({tag, ".ex_imm"}, bus.ex_imm, tbl[i].epc << 4);
            chk({tag, ".ex_funct"}, 32'(bus.ex_funct), 32'(tbl[i].epc[5:2]));
            chk({tag, ".ex_rd"}, 32'(bus.ex_rd), 32'(tbl[i].erd));
            chk({tag, ".ex_mem_read"}, 32'(bus.ex_mem_read), 32'(tbl[i].emr));
            chk({tag, ".ex_reg_write"}, 32'(bus.ex_reg_write), 32'(tbl[i].erw));
            chk({tag, ".ex_alu_op"}, 32'(bus.ex_alu_op), 32'(tbl[i].ealu));
            chk({tag, ".ex_misc_ctl"}, 32'({bus.ex_alu_src, bus.ex_alu_res_src, bus.ex_mem_write, bus.ex_branch, bus.ex_mem_to_reg}),
                32'({5{tbl[i].ev}}));
            chk({tag, ".bubble_cnt"}, 32'(bus.bubble_cnt), 32'(tbl[i].bc));
            chk({tag, ".flush_cnt"}, 32'(bus.flush_cnt), 32'(tbl[i].fc));
            if (i == 0) begin
                chk("pass.ex_rs1", 32'(bus.ex_rs1), 1);
                chk("pass.ex_rs2", 32'(bus.ex_rs2), 2);
                chk("pass.ex_rs2_data", bus.ex_rs2_data, 32'h5);
            end
        end

        // async reset in the middle of a pending load-use hazard
        @(negedge clk);
        drive('{1, 'h4C, 'h1B, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        @(negedge clk);
        drive('{1, 'h50, 'h1C, 5, 0, 6, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        #1 chk("midrst.pre_stall", 32'(bus.stall_if_id), 1);
        #1 rst = 1'b1;
        #1 chk_zero("midrst");
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst.ex_valid", 32'(bus.ex_valid), 1);
        chk("postrst.ex_pc", bus.ex_pc, 32'h50);
        chk("postrst.ex_reg_write", 32'(bus.ex_reg_write), 1);

        // flush counter saturation
        @(negedge clk) bus.flush = 1'b1;
        repeat (65535) @(posedge clk);
        #1 chk("sat.flush_cnt_max", 32'(bus.flush_cnt), 32'hFFFF);
        repeat (4) @(posedge clk);
        #1;
        chk("sat.flush_cnt_hold", 32'(bus.flush_cnt), 32'hFFFF);
        chk("sat.bubble_cnt", 32'(bus.bubble_cnt), 0);
        chk("sat.ex_valid", 32'(bus.ex_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
